// File: rtl/conv3x3_engine_if.sv
// conv3x3_engine <-> layer_mem link: result write strobe
// and pooling handshake.
interface conv3x3_engine_if #(
  parameter int ADDR_LEN = 9
);
  logic                store;
  logic [3:0]          out_c;
  logic [ADDR_LEN:0]   w_addr;
  logic signed [7:0]   value;
  logic                cout_done;
  logic                pool;
  logic                pool_done;

  modport master (
    output store, out_c, w_addr, value,
    output cout_done, pool,
    input  pool_done
  );

  modport slave (
    input  store, out_c, w_addr, value,
    input  cout_done, pool,
    output pool_done
  );
endinterface

// File: rtl/conv3x3_engine.sv
// Zero-padded 3x3 stride-1 convolution sequencer
// writing requantized results into layer_mem.
module conv3x3_engine #(
  parameter int W        = 28,
  parameter int IC       = 0,
  parameter int OC       = 7,
  parameter int ADDR_LEN = 9,
  parameter int PX_AW    = 12,
  parameter int WT_AW    = 10,
  parameter int SHIFT    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [PX_AW-1:0]        px_addr,
  input  logic signed [7:0]       px_data,
  output logic [WT_AW-1:0]        wt_addr,
  input  logic signed [7:0]       wt_data,
  output logic                    busy,
  output logic                    done,
  conv3x3_engine_if.master        lm
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (IC > 0) ? $clog2(IC + 1) : 1;
  localparam int AW = 20 + IW;

  typedef enum logic [2:0] {
    IDLE, MAC, ACC, STORE, POOL, FIN
  } state_t;

  state_t st, st_n;
  logic [3:0] oc, oc_n;
  logic [CW-1:0] y, y_n, x, x_n;
  logic [IW-1:0] ic, ic_n;
  logic [1:0] ky, ky_n, kx, kx_n;
  logic vld, vld_n, first, first_n;
  logic pad, pad_n, issue;
  logic signed [AW-1:0] acc, acc_n, shd;
  logic signed [15:0] prod;
  logic signed [7:0] sat, val_n;
  logic [PX_AW-1:0] px_n;
  logic [WT_AW-1:0] wt_n;
  logic [ADDR_LEN:0] wa_n;
  logic [3:0] outc_n;
  logic store_n, cout_n, pool_n;
  logic busy_n, done_n, ovf;
  logic last_tap, last_x, last_y;
  int yy, xx;

  assign prod = pad ? 16'sd0
              : 16'(px_data) * 16'(wt_data);
  assign last_tap = (ic == IW'(IC))
                 && (ky == 2'd2) && (kx == 2'd2);
  assign last_x = (x == CW'(W - 1));
  assign last_y = (y == CW'(W - 1));

  // floor shift, then clamp to the signed 8-bit range
  assign shd = acc >>> SHIFT;
  assign ovf = !((&shd[AW-1:7]) || !(|shd[AW-1:7]));
  assign sat = ovf ? (shd[AW-1] ? 8'sh80 : 8'sh7f)
                   : shd[7:0];

  always_comb begin
    st_n    = st;
    oc_n    = oc;
    y_n     = y;
    x_n     = x;
    ic_n    = ic;
    ky_n    = ky;
    kx_n    = kx;
    vld_n   = 1'b0;
    first_n = first;
    pad_n   = pad;
    issue   = 1'b0;
    px_n    = px_addr;
    wt_n    = wt_addr;
    store_n = 1'b0;
    cout_n  = 1'b0;
    done_n  = 1'b0;
    pool_n  = lm.pool;
    wa_n    = lm.w_addr;
    outc_n  = lm.out_c;
    val_n   = lm.value;
    acc_n   = acc;
    if (vld)
      acc_n = AW'(prod) + (first ? '0 : acc);
    unique case (st)
      IDLE: begin
        if (start && !lm.pool_done) begin
          st_n  = MAC;
          oc_n  = '0;
          y_n   = '0;
          x_n   = '0;
          ic_n  = '0;
          ky_n  = '0;
          kx_n  = '0;
          issue = 1'b1;
        end
      end
      MAC: begin
        if (last_tap) begin
          st_n = ACC;
        end else begin
          issue = 1'b1;
          if (kx != 2'd2) begin
            kx_n = kx + 2'd1;
          end else begin
            kx_n = '0;
            if (ky != 2'd2) begin
              ky_n = ky + 2'd1;
            end else begin
              ky_n = '0;
              ic_n = ic + 1'b1;
            end
          end
        end
      end
      ACC: begin
        st_n    = STORE;
        store_n = 1'b1;
        val_n   = sat;
        outc_n  = oc;
        wa_n    = (ADDR_LEN + 1)'(int'(y) * W
                                  + int'(x));
      end
      STORE: begin
        ic_n  = '0;
        ky_n  = '0;
        kx_n  = '0;
        st_n  = MAC;
        issue = 1'b1;
        if (!last_x) begin
          x_n = x + 1'b1;
        end else begin
          x_n = '0;
          if (!last_y) begin
            y_n = y + 1'b1;
          end else begin
            y_n    = '0;
            cout_n = 1'b1;
            if (oc == 4'(OC)) begin
              st_n  = POOL;
              issue = 1'b0;
            end else begin
              oc_n = oc + 4'd1;
            end
          end
        end
      end
      POOL: begin
        if (lm.pool_done) begin
          pool_n = 1'b0;
          st_n   = FIN;
        end else begin
          pool_n = 1'b1;
        end
      end
      FIN: begin
        if (!lm.pool_done) begin
          done_n = 1'b1;
          st_n   = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
    yy = int'(y_n) + int'(ky_n) - 1;
    xx = int'(x_n) + int'(kx_n) - 1;
    if (issue) begin
      vld_n   = 1'b1;
      first_n = (ic_n == '0) && (ky_n == '0)
             && (kx_n == '0);
      pad_n   = (yy < 0) || (yy >= W)
             || (xx < 0) || (xx >= W);
      px_n    = pad_n ? '0
              : PX_AW'(int'(ic_n) * W * W
                       + yy * W + xx);
      wt_n    = WT_AW'((int'(oc_n) * (IC + 1)
                        + int'(ic_n)) * 9
                       + int'(ky_n) * 3
                       + int'(kx_n));
    end
    busy_n = (st_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= IDLE;
      oc           <= '0;
      y            <= '0;
      x            <= '0;
      ic           <= '0;
      ky           <= '0;
      kx           <= '0;
      vld          <= 1'b0;
      first        <= 1'b0;
      pad          <= 1'b0;
      acc          <= '0;
      px_addr      <= '0;
      wt_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      lm.store     <= 1'b0;
      lm.out_c     <= '0;
      lm.w_addr    <= '0;
      lm.value     <= '0;
      lm.cout_done <= 1'b0;
      lm.pool      <= 1'b0;
    end else begin
      st           <= st_n;
      oc           <= oc_n;
      y            <= y_n;
      x            <= x_n;
      ic           <= ic_n;
      ky           <= ky_n;
      kx           <= kx_n;
      vld          <= vld_n;
      first        <= first_n;
      pad          <= pad_n;
      acc          <= acc_n;
      px_addr      <= px_n;
      wt_addr      <= wt_n;
      busy         <= busy_n;
      done         <= done_n;
      lm.store     <= store_n;
      lm.out_c     <= outc_n;
      lm.w_addr    <= wa_n;
      lm.value     <= val_n;
      lm.cout_done <= cout_n;
      lm.pool      <= pool_n;
    end
  end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine: two instances
// (SHIFT 0 and 7) share one pixel/weight model.
module tb_conv3x3_engine;
  localparam int W  = 4;
  localparam int IC = 0;
  localparam int OC = 1;
  localparam int NW = (OC + 1) * (IC + 1) * 9;

  typedef struct {
    int oc;
    int wa;
    int v;
  } exp_t;

  logic clk, rst, start, pool_done, sel;
  logic start0, start1;
  logic [11:0] px_addr0, px_addr1;
  logic [9:0] wt_addr0, wt_addr1;
  logic signed [7:0] px_data0, px_data1;
  logic signed [7:0] wt_data0, wt_data1;
  logic busy0, busy1, done0, done1;
  logic signed [7:0] pix [16];
  logic signed [7:0] wt [NW];

  logic m_store, m_cout, m_pool, m_busy, m_done;
  logic [3:0] m_outc;
  logic [9:0] m_wa, m_wt;
  logic [11:0] m_px;
  logic signed [7:0] m_val;

  int n_cmp, n_bad, cyc, last_st, t_start;
  int n_store, n_cout, n_done;
  exp_t sbq [$];

  conv3x3_engine_if #(.ADDR_LEN(9)) i0 ();
  conv3x3_engine_if #(.ADDR_LEN(9)) i1 ();

  conv3x3_engine #(
    .W(W), .IC(IC), .OC(OC), .ADDR_LEN(9),
    .PX_AW(12), .WT_AW(10), .SHIFT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .px_addr(px_addr0), .px_data(px_data0),
    .wt_addr(wt_addr0), .wt_data(wt_data0),
    .busy(busy0), .done(done0), .lm(i0.master)
  );

  conv3x3_engine #(
    .W(W), .IC(IC), .OC(OC), .ADDR_LEN(9),
    .PX_AW(12), .WT_AW(10), .SHIFT(7)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .px_addr(px_addr1), .px_data(px_data1),
    .wt_addr(wt_addr1), .wt_data(wt_data1),
    .busy(busy1), .done(done1), .lm(i1.master)
  );

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign i0.pool_done = pool_done;
  assign i1.pool_done = pool_done;

  assign px_data0 = pix[px_addr0[3:0]];
  assign px_data1 = pix[px_addr1[3:0]];
  assign wt_data0 = (int'(wt_addr0) < NW)
                  ? wt[wt_addr0[4:0]] : 8'sd0;
  assign wt_data1 = (int'(wt_addr1) < NW)
                  ? wt[wt_addr1[4:0]] : 8'sd0;

  assign m_store = sel ? i1.store : i0.store;
  assign m_cout  = sel ? i1.cout_done
                       : i0.cout_done;
  assign m_pool  = sel ? i1.pool : i0.pool;
  assign m_outc  = sel ? i1.out_c : i0.out_c;
  assign m_wa    = sel ? i1.w_addr : i0.w_addr;
  assign m_val   = sel ? i1.value : i0.value;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_px    = sel ? px_addr1 : px_addr0;
  assign m_wt    = sel ? wt_addr1 : wt_addr0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d",
               tag, got, want);
    end
  endtask

  function automatic int exp_val(int oc, int y,
                                 int x, int sh);
    int s, yy, xx, r;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        yy = y + ky - 1;
        xx = x + kx - 1;
        if (yy >= 0 && yy < W && xx >= 0 && xx < W)
          s += int'(pix[yy * W + xx])
             * int'(wt[oc * 9 + ky * 3 + kx]);
      end
    r = s >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!m_busy) last_st = -1;
    if (m_store) begin
      chk("store_pool_excl", int'(m_pool), 0);
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("out_c", int'(m_outc), e.oc);
        chk("w_addr", int'(m_wa), e.wa);
        chk("value", int'(m_val), e.v);
      end
      if (last_st >= 0)
        chk("store_spacing", cyc - last_st, 11);
      else
        chk("first_store_lat", cyc - t_start, 10);
      last_st = cyc;
      n_store++;
    end
    if (m_cout) n_cout++;
    if (m_done) n_done++;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int oc = 0; oc <= OC; oc++)
      for (int y = 0; y < W; y++)
        for (int x = 0; x < W; x++) begin
          e.oc = oc;
          e.wa = y * W + x;
          e.v  = exp_val(oc, y, x, sel ? 7 : 0);
          sbq.push_back(e);
        end
  endtask

  task automatic fill(input int p, input int w,
                      input bit ctr);
    for (int i = 0; i < 16; i++) pix[i] = 8'(p);
    for (int j = 0; j < NW; j++)
      wt[j] = (!ctr || (j % 9 == 4)) ? 8'(w) : 8'sd0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++)
      pix[i] = 8'($urandom_range(255));
    for (int j = 0; j < NW; j++)
      wt[j] = 8'($urandom_range(255));
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, int'(m_busy), 0);
    chk({pfx, "_store"}, int'(m_store), 0);
    chk({pfx, "_pool"}, int'(m_pool), 0);
    chk({pfx, "_done"}, int'(m_done), 0);
    chk({pfx, "_cout"}, int'(m_cout), 0);
    chk({pfx, "_value"}, int'(m_val), 0);
    chk({pfx, "_w_addr"}, int'(m_wa), 0);
    chk({pfx, "_out_c"}, int'(m_outc), 0);
    chk({pfx, "_px_addr"}, int'(m_px), 0);
    chk({pfx, "_wt_addr"}, int'(m_wt), 0);
  endtask

  task automatic run_layer(input bit dbl);
    int s0, c0, d0;
    bit got;
    s0 = n_store;
    c0 = n_cout;
    d0 = n_done;
    push_exp();
    start = 1'b1;
    step();
    start = 1'b0;
    t_start = cyc;
    chk("start_busy", int'(m_busy), 1);
    got = 1'b0;
    for (int i = 0; i < 1500 && !got; i++) begin
      if (dbl && i == 40) start = 1'b1;
      step();
      start = 1'b0;
      got = m_pool;
    end
    chk("pool_seen", int'(got), 1);
    if (!got) return;
    chk("store_count", n_store - s0, 32);
    chk("cout_count", n_cout - c0, 2);
    chk("sb_left", sbq.size(), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pool_hold", int'(m_pool), 1);
    end
    pool_done = 1'b1;
    step();
    chk("pool_drop", int'(m_pool), 0);
    chk("fin_busy", int'(m_busy), 1);
    chk("fin_no_done", int'(m_done), 0);
    pool_done = 1'b0;
    step();
    chk("done_pulse", int'(m_done), 1);
    step();
    chk("done_clear", int'(m_done), 0);
    chk("idle_busy", int'(m_busy), 0);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int s0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    last_st = -1; t_start = 0;
    n_store = 0; n_cout = 0; n_done = 0;
    rst = 1'b0;
    start = 1'b0;
    pool_done = 1'b0;
    sel = 1'b0;
    fill(1, 1, 1'b0);
    repeat (2) step();
    chk_zero("reset");
    rst = 1'b1;
    step();

    run_layer(1'b1);

    push_exp();
    s0 = n_store;
    start = 1'b1;
    step();
    start = 1'b0;
    t_start = cyc;
    for (int i = 0; i < 400 && n_store - s0 < 5; i++)
      step();
    chk("pre_rst_stores", n_store - s0, 5);
    repeat (3) step();
    #2 rst = 1'b0;
    #1 chk_zero("midrst");
    sbq.delete();
    step();
    rst = 1'b1;
    step();
    run_layer(1'b0);

    fill(127, 127, 1'b0);
    run_layer(1'b0);
    fill(-128, 127, 1'b0);
    run_layer(1'b0);

    sel = 1'b1;
    step();
    fill(-1, 1, 1'b1);
    run_layer(1'b0);
    fill(3, 64, 1'b1);
    run_layer(1'b0);
    fill_rand();
    run_layer(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
